// File: rtl/router_pkt_tx.sv
// Packet source for a router input port: buffers a payload, then sends header, payload and parity.
// Optional build macro ROUTER_PKT_TX_PARITY_CORRUPT_EN adds a corrupt_parity input that inverts the parity byte.
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    output logic       cmd_ready,
    output logic       cmd_err,
    input  logic [7:0] pld_data,
    input  logic       pld_valid,
    output logic       pld_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       done
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    ,
    input  logic       corrupt_parity
`endif
);

    localparam logic [5:0] LP_MAX_LEN = 6'(MAX_LEN);
    localparam int LP_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LP_GW-1:0] LP_GAP_LAST = LP_GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PLD,
        S_PAR,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [7:0]       r_header;
    logic [7:0]       r_parity;
    logic [5:0]       r_len;
    logic [5:0]       r_wr_ptr;
    logic [5:0]       r_rd_ptr;
    logic [LP_GW-1:0] r_gap_cnt;
    logic [7:0]       r_buf [0:MAX_LEN-1];
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    logic             r_corrupt;
`endif

    logic       w_cmd_ok;
    logic       w_wr_en;
    logic       w_last_wr;
    logic       w_last_rd;
    logic [5:0] w_rd_next;
    logic [7:0] w_par_byte;

    assign w_cmd_ok  = (dest != 2'b11) && (len != 6'd0) && (len <= LP_MAX_LEN);
    assign w_wr_en   = (r_state == S_LOAD) && pld_valid;
    assign w_last_wr = (r_wr_ptr == r_len - 6'd1);
    assign w_last_rd = (r_rd_ptr == r_len - 6'd1);
    assign w_rd_next = r_rd_ptr + 6'd1;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    assign w_par_byte = r_corrupt ? ~r_parity : r_parity;
`else
    assign w_par_byte = r_parity;
`endif

    // NOTE: the payload buffer has no reset; its contents are only read after being written in LOAD.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr] <= pld_data;
        end
    end

    // NOTE: all state updates use <= so every branch sees the pre-edge values of r_parity, pointers, etc.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_header  <= 8'h00;
            r_parity  <= 8'h00;
            r_len     <= 6'd0;
            r_wr_ptr  <= 6'd0;
            r_rd_ptr  <= 6'd0;
            r_gap_cnt <= '0;
            cmd_ready <= 1'b1;
            cmd_err   <= 1'b0;
            pld_ready <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            done      <= 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
            r_corrupt <= 1'b0;
`endif
        end else begin
            cmd_err <= 1'b0;
            done    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cmd_ok) begin
                            r_header  <= {len, dest};
                            r_parity  <= {len, dest};
                            r_len     <= len;
                            r_wr_ptr  <= 6'd0;
                            cmd_ready <= 1'b0;
                            pld_ready <= 1'b1;
                            r_state   <= S_LOAD;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
                            r_corrupt <= corrupt_parity;
`endif
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (pld_valid) begin
                        r_parity <= r_parity ^ pld_data;
                        r_wr_ptr <= r_wr_ptr + 6'd1;
                        if (w_last_wr) begin
                            pld_ready <= 1'b0;
                            pkt_valid <= 1'b1;
                            data_out  <= r_header;
                            r_state   <= S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    if (!busy) begin
                        r_rd_ptr <= 6'd0;
                        data_out <= r_buf[0];
                        r_state  <= S_PLD;
                    end
                end
                // data_out is preloaded with the next byte so unstalled bytes leave back-to-back.
                S_PLD: begin
                    if (!busy) begin
                        if (w_last_rd) begin
                            pkt_valid <= 1'b0;
                            data_out  <= w_par_byte;
                            r_state   <= S_PAR;
                        end else begin
                            r_rd_ptr <= w_rd_next;
                            data_out <= r_buf[w_rd_next];
                        end
                    end
                end
                S_PAR: begin
                    if (!busy) begin
                        data_out  <= 8'h00;
                        r_gap_cnt <= LP_GAP_LAST;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        cmd_ready <= 1'b1;
                        done      <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    pld_ready <= 1'b0;
                    pkt_valid <= 1'b0;
                    data_out  <= 8'h00;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: command table plus hand-written packet, stall and reset sequences.
// Build with ROUTER_PKT_TX_PARITY_CORRUPT_EN to cover the corrupted-parity path.
module tb_router_pkt_tx;

    localparam int MAX_LEN    = 63;
    localparam int GAP_CYCLES = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest = 2'b00;
    logic [5:0] len = 6'd0;
    logic       cmd_ready;
    logic       cmd_err;
    logic [7:0] pld_data = 8'h00;
    logic       pld_valid = 1'b0;
    logic       pld_ready;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       done;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    logic       corrupt_parity = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] payload [64];

    typedef struct {
        logic [1:0] d;
        logic [5:0] l;
        bit         exp_err;
    } cmd_vec_t;

    cmd_vec_t cmd_tbl [7];

    router_pkt_tx #(
        .MAX_LEN   (MAX_LEN),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .dest     (dest),
        .len      (len),
        .cmd_ready(cmd_ready),
        .cmd_err  (cmd_err),
        .pld_data (pld_data),
        .pld_valid(pld_valid),
        .pld_ready(pld_ready),
        .busy     (busy),
        .pkt_valid(pkt_valid),
        .data_out (data_out),
        .done     (done)
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        ,
        .corrupt_parity(corrupt_parity)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one full packet and checks every link cycle; stall_idx/reset_idx < 0 disable those events.
    task automatic run_packet(input logic [1:0] d, input logic [5:0] l, input bit toggle,
                              input int stall_idx, input int stall_n, input bit corrupt,
                              input int reset_idx, input bit start_in_load);
        logic [7:0] exp_stream [66];
        logic [7:0] par;
        int         i;
        par = {l, d};
        exp_stream[0] = {l, d};
        for (int k = 0; k < int'(l); k++) begin
            exp_stream[k+1] = payload[k];
            par = par ^ payload[k];
        end
        exp_stream[int'(l)+1] = corrupt ? ~par : par;

        start = 1'b1;
        dest  = d;
        len   = l;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        corrupt_parity = corrupt;
`endif
        tick;
        start = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        corrupt_parity = 1'b0;
`endif
        check("cmd_accept", 32'({cmd_ready, pld_ready, cmd_err, pkt_valid}), 32'(4'b0100));

        if (start_in_load) begin
            start = 1'b1;
            dest  = 2'b11;
            len   = 6'd0;
        end
        i = 0;
        for (int c = 0; c < 4 * MAX_LEN + 8 && i < int'(l); c++) begin
            pld_valid = toggle ? c[0] : 1'b1;
            pld_data  = payload[i];
            tick;
            if (pld_valid) i++;
        end
        pld_valid = 1'b0;
        start     = 1'b0;
        check("hdr_entry", 32'({pld_ready, cmd_err, cmd_ready}), 32'(3'b000));

        for (int s = 0; s <= int'(l) + 1; s++) begin
            check($sformatf("link_byte%0d", s), 32'({pkt_valid, data_out}),
                  32'({s <= int'(l), exp_stream[s]}));
            if (s == stall_idx) begin
                busy = 1'b1;
                for (int k = 0; k < stall_n; k++) begin
                    tick;
                    check($sformatf("stall_hold%0d_%0d", s, k), 32'({pkt_valid, data_out}),
                          32'({s <= int'(l), exp_stream[s]}));
                end
                busy = 1'b0;
            end
            if (s == reset_idx) begin
                resetn = 1'b0;
                tick;
                resetn = 1'b1;
                check("reset_abort", 32'({cmd_ready, pld_ready, pkt_valid, cmd_err, done, data_out}),
                      32'({5'b10000, 8'h00}));
                return;
            end
            tick;
        end

        for (int g = 0; g < GAP_CYCLES; g++) begin
            check($sformatf("gap%0d", g), 32'({cmd_ready, pkt_valid, done, data_out}),
                  32'({3'b000, 8'h00}));
            tick;
        end
        check("done_pulse", 32'({cmd_ready, done, pkt_valid}), 32'(3'b110));
        tick;
        check("done_clear", 32'({cmd_ready, done}), 32'(2'b10));
    endtask

    initial begin
        cmd_tbl[0] = '{d: 2'd3, l: 6'd4,  exp_err: 1'b1};
        cmd_tbl[1] = '{d: 2'd0, l: 6'd0,  exp_err: 1'b1};
        cmd_tbl[2] = '{d: 2'd3, l: 6'd0,  exp_err: 1'b1};
        cmd_tbl[3] = '{d: 2'd3, l: 6'd63, exp_err: 1'b1};
        cmd_tbl[4] = '{d: 2'd1, l: 6'd0,  exp_err: 1'b1};
        cmd_tbl[5] = '{d: 2'd0, l: 6'd1,  exp_err: 1'b0};
        cmd_tbl[6] = '{d: 2'd2, l: 6'd63, exp_err: 1'b0};

        resetn = 1'b0;
        tick;
        tick;
        resetn = 1'b1;
        check("reset_state", 32'({cmd_ready, pld_ready, pkt_valid, cmd_err, done, data_out}),
              32'({5'b10000, 8'h00}));

        for (int v = 0; v < 7; v++) begin
            start = 1'b1;
            dest  = cmd_tbl[v].d;
            len   = cmd_tbl[v].l;
            tick;
            start = 1'b0;
            if (cmd_tbl[v].exp_err) begin
                check($sformatf("cmd_reject%0d", v), 32'({cmd_err, cmd_ready, pld_ready, pkt_valid}),
                      32'(4'b1100));
                tick;
                check($sformatf("cmd_err_clear%0d", v), 32'({cmd_err, cmd_ready, pld_ready}),
                      32'(3'b010));
            end else begin
                check($sformatf("cmd_load%0d", v), 32'({cmd_err, cmd_ready, pld_ready, pkt_valid}),
                      32'(4'b0010));
                resetn = 1'b0;
                tick;
                resetn = 1'b1;
                check($sformatf("load_reset%0d", v), 32'({cmd_ready, pld_ready}), 32'(2'b10));
            end
        end

        payload[0] = 8'hAA;
        payload[1] = 8'h55;
        payload[2] = 8'h0F;
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
        run_packet(2'd1, 6'd3, 1'b0, -1, 0, 1'b1, -1, 1'b0);
`else
        run_packet(2'd1, 6'd3, 1'b0, -1, 0, 1'b0, -1, 1'b0);
`endif
        run_packet(2'd1, 6'd3, 1'b0, 2, 3, 1'b0, -1, 1'b1);
        run_packet(2'd1, 6'd3, 1'b0, 0, 5, 1'b0, -1, 1'b0);
        run_packet(2'd1, 6'd3, 1'b0, -1, 0, 1'b0, 3, 1'b0);
        run_packet(2'd0, 6'd3, 1'b0, -1, 0, 1'b0, -1, 1'b0);

        for (int k = 0; k < 63; k++) payload[k] = 8'(k);
        run_packet(2'd2, 6'd63, 1'b1, -1, 0, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
